// File: rtl/ariane_pkg.sv
// Shared core definitions used by the ALU writeback buffer and the scoreboard.
package ariane_pkg;

   localparam int unsigned NR_SB_ENTRIES = 16;
   localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

   // One buffered ALU result as it travels to the scoreboard writeback port.
   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [63:0]              result;
      logic                     branch_res;
   } alu_wb_t;

endpackage

// File: rtl/alu_wb_buffer.sv
// In-order result buffer between the ALU and the scoreboard writeback port.
// Absorbs writeback back-pressure; flush discards every buffered result.
module alu_wb_buffer #(
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     alu_valid_i,
   output logic                     alu_ready_o,
   input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
   input  logic [63:0]              alu_result_i,
   input  logic                     alu_branch_res_i,
   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
   output logic [63:0]              wb_result_o,
   output logic                     wb_branch_res_o,
   output logic                     full_o,
   output logic                     empty_o
);
   import ariane_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   alu_wb_t          mem [DEPTH];
   alu_wb_t          wdata;
   alu_wb_t          head;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Status comes from the count register only, so ready never depends on wb_ready_i.
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = alu_valid_i & ~full & ~flush_i;
   assign pop   = ~empty & wb_ready_i & ~flush_i;

   assign wdata.trans_id   = alu_trans_id_i;
   assign wdata.result     = alu_result_i;
   assign wdata.branch_res = alu_branch_res_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; stale contents are hidden by the empty gating below.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= wdata;
   end

   assign head = empty ? '0 : mem[rd_ptr_q];

   assign alu_ready_o     = ~full;
   assign wb_valid_o      = ~empty;
   assign wb_trans_id_o   = head.trans_id;
   assign wb_result_o     = head.result;
   assign wb_branch_res_o = head.branch_res;
   assign full_o          = full;
   assign empty_o         = empty;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: a cycle model queues accepted results,
// a negedge monitor compares every writeback and status flag against it.
module tb_alu_wb_buffer;
   import ariane_pkg::*;

   localparam int DEPTH = 2;
   localparam int TIB   = TRANS_ID_BITS;

   logic           clk = 1'b0;
   logic           rst_ni = 1'b1;
   logic           flush_i = 1'b0;
   logic           alu_valid_i = 1'b0;
   logic           alu_ready_o;
   logic [TIB-1:0] alu_trans_id_i = '0;
   logic [63:0]    alu_result_i = '0;
   logic           alu_branch_res_i = 1'b0;
   logic           wb_valid_o;
   logic           wb_ready_i = 1'b0;
   logic [TIB-1:0] wb_trans_id_o;
   logic [63:0]    wb_result_o;
   logic           wb_branch_res_o;
   logic           full_o;
   logic           empty_o;

   int      nchecks = 0;
   int      nerrors = 0;
   int      mcount  = 0;
   alu_wb_t exp_q[$];

   alu_wb_buffer #(.DEPTH(DEPTH), .TRANS_ID_BITS(TIB)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .alu_valid_i      (alu_valid_i),
      .alu_ready_o      (alu_ready_o),
      .alu_trans_id_i   (alu_trans_id_i),
      .alu_result_i     (alu_result_i),
      .alu_branch_res_i (alu_branch_res_i),
      .wb_valid_o       (wb_valid_o),
      .wb_ready_i       (wb_ready_i),
      .wb_trans_id_o    (wb_trans_id_o),
      .wb_result_o      (wb_result_o),
      .wb_branch_res_o  (wb_branch_res_o),
      .full_o           (full_o),
      .empty_o          (empty_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the buffer should accept and hold after each edge.
   always @(posedge clk) begin
      if (rst_ni) begin
         bit acc;
         bit pp;
         alu_wb_t e;
         acc = alu_valid_i && (mcount < DEPTH) && !flush_i;
         pp  = (mcount > 0) && wb_ready_i && !flush_i;
         if (flush_i) begin
            exp_q.delete();
            mcount = 0;
         end else begin
            if (acc) begin
               e.trans_id   = alu_trans_id_i;
               e.result     = alu_result_i;
               e.branch_res = alu_branch_res_i;
               exp_q.push_back(e);
            end
            mcount = mcount + (acc ? 1 : 0) - (pp ? 1 : 0);
         end
      end
   end

   always @(negedge rst_ni) begin
      exp_q.delete();
      mcount = 0;
   end

   // Monitor: status flags every cycle, head fields whenever valid.
   always @(negedge clk) begin
      if (rst_ni) begin
         chk("wb_valid", wb_valid_o, mcount > 0);
         chk("alu_ready", alu_ready_o, mcount < DEPTH);
         chk("full", full_o, mcount == DEPTH);
         chk("empty", empty_o, mcount == 0);
         if (wb_valid_o) begin
            if (exp_q.size() == 0) begin
               nchecks++;
               nerrors++;
               $display("FAIL unexpected_head: got id %0d expected no entry at %0t", wb_trans_id_o, $time);
            end else begin
               chk("head_id", wb_trans_id_o, exp_q[0].trans_id);
               chk("head_result", wb_result_o, exp_q[0].result);
               chk("head_branch", wb_branch_res_o, exp_q[0].branch_res);
               if (wb_ready_i && !flush_i) void'(exp_q.pop_front());
            end
         end else begin
            chk("gated_id", wb_trans_id_o, 0);
            chk("gated_result", wb_result_o, 0);
         end
      end
   end

   task automatic step(input logic v, input logic [TIB-1:0] id, input logic [63:0] r,
                       input logic b, input logic wr, input logic fl);
      alu_valid_i      = v;
      alu_trans_id_i   = id;
      alu_result_i     = r;
      alu_branch_res_i = b;
      wb_ready_i       = wr;
      flush_i          = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, alu_ready_o, 1);
      chk({tag, "_valid"}, wb_valid_o, 0);
      chk({tag, "_empty"}, empty_o, 1);
      chk({tag, "_full"}, full_o, 0);
      chk({tag, "_result"}, wb_result_o, 0);
      chk({tag, "_id"}, wb_trans_id_o, 0);
      chk({tag, "_branch"}, wb_branch_res_o, 0);
   endtask

   logic [TIB-1:0] h_id;
   logic [63:0]    h_res;
   logic           h_br;

   initial begin
      // Reset asserted mid-cycle: outputs must settle without a clock edge.
      #2 rst_ni = 1'b0;
      #1 chk_reset_outputs("rst_async");
      @(posedge clk);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      chk_reset_outputs("rst_release");
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Single push, drained immediately.
      step(1, 3, 64'hDEAD_BEEF_0000_0001, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Back-pressure fill; id 3 held until space frees.
      step(1, 1, 64'h0000_0000_0000_1111, 0, 0, 0);
      step(1, 2, 64'h0000_0000_0000_2222, 1, 0, 0);
      step(1, 3, 64'h0000_0000_0000_3333, 0, 0, 0);
      step(1, 3, 64'h0000_0000_0000_3333, 0, 1, 0);
      step(1, 3, 64'h0000_0000_0000_3333, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Streaming through several pointer wraps.
      for (int i = 0; i < 10; i++)
         step(1, TIB'(i), 64'hA5A5_0000_0000_0000 | 64'(i), i[0], 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Flush with two buffered plus a same-cycle push.
      step(1, 4, 64'h0000_0000_0000_0004, 0, 0, 0);
      step(1, 5, 64'h0000_0000_0000_0005, 1, 0, 0);
      step(1, 7, 64'h0000_0000_0000_0007, 1, 0, 1);
      chk("post_flush_valid", wb_valid_o, 0);
      chk("post_flush_empty", empty_o, 1);
      chk("post_flush_ready", alu_ready_o, 1);
      step(1, 8, 64'h0000_0000_0000_0008, 0, 0, 0);
      chk("after_flush_head", wb_trans_id_o, 8);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Head stability under a five-cycle stall.
      step(1, 5, 64'h5555_AAAA_0000_0005, 1, 0, 0);
      alu_valid_i = 1'b0;
      @(negedge clk);
      h_id  = wb_trans_id_o;
      h_res = wb_result_o;
      h_br  = wb_branch_res_o;
      chk("stall_first_id", h_id, 5);
      chk("stall_first_res", h_res, 64'h5555_AAAA_0000_0005);
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_id", wb_trans_id_o, h_id);
         chk("stall_res", wb_result_o, h_res);
         chk("stall_br", wb_branch_res_o, h_br);
      end
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Asynchronous reset while full.
      step(1, 10, 64'h0000_0000_0000_000A, 1, 0, 0);
      step(1, 11, 64'h0000_0000_0000_000B, 0, 0, 0);
      alu_valid_i = 1'b0;
      chk("pre_reset_full", full_o, 1);
      @(negedge clk);
      #2 rst_ni = 1'b0;
      #1 chk_reset_outputs("rst_midop");
      @(posedge clk);
      #1 rst_ni = 1'b1;
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      chk("queue_drained", 64'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Sits directly downstream of the ALU. Captures each ALU result together with its transaction ID and branch-compare bit.
- Presents these results in order on the ALU writeback port to the scoreboard.
- Absorbs writeback back-pressure with a small FIFO, so the issue stage stalls only when the buffer is full.
- Supports a pipeline flush that discards all buffered results.

Parameters:
- DEPTH, 2, number of buffered results; power of two, at least 2.
- TRANS_ID_BITS, ariane_pkg::TRANS_ID_BITS, width of the scoreboard transaction ID.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered entries and any same-cycle push
- alu_valid_i  in  1  ALU result valid this cycle
- alu_ready_o  out  1  buffer can accept a result
- alu_trans_id_i  in  TRANS_ID_BITS  ID of the incoming result
- alu_result_i  in  64  ALU result_o
- alu_branch_res_i  in  1  ALU alu_branch_res_o
- wb_valid_o  out  1  head entry valid
- wb_ready_i  in  1  scoreboard accepts the head entry
- wb_trans_id_o  out  TRANS_ID_BITS  head entry ID
- wb_result_o  out  64  head entry result
- wb_branch_res_o  out  1  head entry branch bit
- full_o  out  1  occupancy equals DEPTH
- empty_o  out  1  occupancy equals 0

Behaviour:
- Reset (rst_ni low, asynchronous):
  - read pointer, write pointer and count are 0.
  - wb_valid_o=0, alu_ready_o=1, full_o=0, empty_o=1.
  - wb_trans_id_o, wb_result_o and wb_branch_res_o are 0.
  - Storage contents are don't-care, but outputs are gated to 0 while empty.
- Push:
  - Occurs when alu_valid_i & alu_ready_o & !flush_i.
  - Writes {trans_id, result, branch_res} at the write pointer; write pointer increments modulo DEPTH.
- Pop:
  - Occurs when wb_valid_o & wb_ready_i & !flush_i.
  - Read pointer increments modulo DEPTH.
- Count:
  - Width $clog2(DEPTH)+1.
  - count_next = count + push - pop.
  - Never exceeds DEPTH and never underflows.
- Outputs and timing:
  - alu_ready_o = !full, derived from registered state only; there is no combinational path from wb_ready_i to alu_ready_o.
  - When full, a same-cycle pop does not enable a push; the push is accepted in the following cycle.
  - wb_valid_o = !empty. Head fields are driven from storage at the read pointer, or 0 when empty.
  - Latency is 1 cycle from an accepted push to wb_valid_o; there is no combinational pass-through.
  - Head fields must stay stable while wb_valid_o & !wb_ready_i.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Flush:
  - Takes priority over push and pop.
  - Next cycle: pointers = 0, count = 0, wb_valid_o = 0, alu_ready_o = 1.
  - The incoming result in the flush cycle is dropped.
  - A head popped in the flush cycle is not considered written back; the scoreboard ignores wb while flushing.
- Ordering: strict FIFO; results leave in acceptance order.
- Pointer wrap: entries written after wrap-around return in the correct order across any number of wraps.
- No state machine beyond the pointer/count registers; the only states are empty, partial and full, encoded by count.
- Reset asserted mid-operation: all entries are lost immediately, and outputs reach their reset values asynchronously.

Decomposition:
- Shared package (ariane_pkg):
  - TRANS_ID_BITS (existing).
  - New packed typedef alu_wb_t {logic [TRANS_ID_BITS-1:0] trans_id; logic [63:0] result; logic branch_res;} used for storage and for wiring to the scoreboard.
- Single module. Storage is an array of alu_wb_t indexed by the pointers; no sub-module is needed. Use of a generic FIFO primitive is not permitted, because flush priority and output gating are block-specific.

Test Plan:
- Reset then idle: with rst_ni held low mid-cycle, outputs go asynchronously to ready=1, wb_valid=0, empty=1, wb_result=0; they hold after release with no push.
- Single push, id=3, result=64'hDEAD_BEEF_0000_0001, branch=1, wb_ready=1: wb_valid rises exactly 1 cycle later with the same fields, pops, and empty=1 on the next cycle.
- Back-pressure fill, wb_ready=0, push ids 1 and 2 (DEPTH=2): full_o=1 and alu_ready_o=0 after the second push. A third valid is not accepted. Raising wb_ready pops id 1, then id 2; the held id 3 is accepted the cycle after the first pop and exits last.
- Streaming with wb_ready=1, 10 consecutive pushes of ids 0..9 (pointers wrap 5 times): output order is 0..9, count never exceeds 1, and alu_ready_o stays 1.
- Flush with 2 entries buffered, plus a simultaneous push of id 7: next cycle wb_valid=0, empty=1, ready=1. id 7 never appears, and the next push of id 8 appears as head 1 cycle later.
- Stall stability, wb_ready=0 for 5 cycles with the head at id 5: wb_trans_id_o, wb_result_o and wb_branch_res_o remain constant every cycle.
